// File: rtl/ice40_sysbus_pkg.sv
// ice40_sysbus_pkg
//   Shared definitions for the iCE40 system-bus arbiter: FSM state encoding,
//   the hard-IP SPI register map (lower address nibble as seen on the SB
//   interface), the default abort limit and a small read-data helper.
package ice40_sysbus_pkg;

   // Bus field widths
   localparam int unsigned SB_ADDR_W = 8;
   localparam int unsigned SB_DATA_W = 8;

   // Default cycles sb_strobe may stay up without sb_ack before aborting
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   // SB_SPI register addresses
   localparam logic [SB_ADDR_W-1:0] SPICR0  = 8'h08;
   localparam logic [SB_ADDR_W-1:0] SPICR1  = 8'h09;
   localparam logic [SB_ADDR_W-1:0] SPICR2  = 8'h0A;
   localparam logic [SB_ADDR_W-1:0] SPIBR   = 8'h0B;
   localparam logic [SB_ADDR_W-1:0] SPISR   = 8'h0C;
   localparam logic [SB_ADDR_W-1:0] SPITXDR = 8'h0D;
   localparam logic [SB_ADDR_W-1:0] SPIRXDR = 8'h0E;
   localparam logic [SB_ADDR_W-1:0] SPICSR  = 8'h0F;

   // Arbiter FSM
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUS     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Data returned to a requester on completion: bus read data only for an
   // acknowledged read; writes and aborted transactions return zero.
   function automatic logic [SB_DATA_W-1:0] completion_data(
      input logic                 rw,
      input logic                 acked,
      input logic [SB_DATA_W-1:0] bus_data
   );
      return (acked && !rw) ? bus_data : '0;
   endfunction

endpackage

// File: rtl/ice40_sysbus_timeout.sv
// ice40_sysbus_timeout
//   Cycle counter for bus-transaction abort detection.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     clear       - force count to zero (has priority over enable)
//     enable      - count one cycle
//     expired     - high during the LIMIT-th enabled cycle since clear
module ice40_sysbus_timeout #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_W'(LIMIT))) begin
         count <= count + 1'b1;
      end
   end

   // The count holds the number of enabled cycles already completed, so the
   // current cycle is the LIMIT-th one when count == LIMIT-1. Flagging it here
   // lets the FSM drop the strobe on the edge that ends that cycle.
   assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ice40_sysbus_arbiter.sv
// ice40_sysbus_arbiter
//   Two-requester round-robin arbiter in front of the iCE40 hard-IP system
//   bus (SB_SPI / SB_I2C). One transaction at a time is placed on sb_*; a
//   transaction ends on sb_ack or after TIMEOUT_CYCLES bus cycles.
//   Ports:
//     clk, reset                 - clock, asynchronous active-high reset
//     reqN_strobe/rw/reg_addr/data_in - requester N transaction request
//     reqN_ack, reqN_data_out    - requester N completion handshake, read data
//     sb_strobe/rw/reg_addr/data_in   - system-bus request (registered)
//     sb_data_out, sb_ack        - system-bus read data and acknowledge
//     timeout_err                - one-cycle pulse on an aborted transaction
//     grant_id                   - current/last granted requester
//   Every output is a flop: no combinational path from inputs to outputs.
module ice40_sysbus_arbiter
   import ice40_sysbus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_strobe,
   input  logic                 req0_rw,
   input  logic [SB_ADDR_W-1:0] req0_reg_addr,
   input  logic [SB_DATA_W-1:0] req0_data_in,
   output logic                 req0_ack,
   output logic [SB_DATA_W-1:0] req0_data_out,
   input  logic                 req1_strobe,
   input  logic                 req1_rw,
   input  logic [SB_ADDR_W-1:0] req1_reg_addr,
   input  logic [SB_DATA_W-1:0] req1_data_in,
   output logic                 req1_ack,
   output logic [SB_DATA_W-1:0] req1_data_out,
   output logic                 sb_strobe,
   output logic                 sb_rw,
   output logic [SB_ADDR_W-1:0] sb_reg_addr,
   output logic [SB_DATA_W-1:0] sb_data_in,
   input  logic [SB_DATA_W-1:0] sb_data_out,
   input  logic                 sb_ack,
   output logic                 timeout_err,
   output logic                 grant_id
);

   state_t               state_q, state_d;
   logic                 prio_ptr_q, prio_ptr_d;
   logic                 grant_d;
   logic                 sb_strobe_d, sb_rw_d;
   logic [SB_ADDR_W-1:0] sb_reg_addr_d;
   logic [SB_DATA_W-1:0] sb_data_in_d;
   logic                 req0_ack_d, req1_ack_d;
   logic [SB_DATA_W-1:0] req0_data_out_d, req1_data_out_d;
   logic                 timeout_err_d;
   logic                 tmo_clear, tmo_enable, tmo_expired;
   logic                 sel;
   logic                 granted_strobe;
   logic [SB_DATA_W-1:0] result;

   ice40_sysbus_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // Next-state and next-output logic; outputs hold unless changed below
   always_comb begin
      state_d         = state_q;
      prio_ptr_d      = prio_ptr_q;
      grant_d         = grant_id;
      sb_strobe_d     = sb_strobe;
      sb_rw_d         = sb_rw;
      sb_reg_addr_d   = sb_reg_addr;
      sb_data_in_d    = sb_data_in;
      req0_ack_d      = req0_ack;
      req1_ack_d      = req1_ack;
      req0_data_out_d = req0_data_out;
      req1_data_out_d = req1_data_out;
      timeout_err_d   = 1'b0;
      tmo_clear       = 1'b0;
      tmo_enable      = 1'b0;
      sel             = prio_ptr_q;
      granted_strobe  = grant_id ? req1_strobe : req0_strobe;
      result          = '0;

      case (state_q)
         ST_IDLE: begin
            tmo_clear = 1'b1;
            if (req0_strobe || req1_strobe) begin
               // Contention resolved by the pointer, otherwise whoever asks
               sel           = (req0_strobe && req1_strobe) ? prio_ptr_q : req1_strobe;
               grant_d       = sel;
               sb_strobe_d   = 1'b1;
               sb_rw_d       = sel ? req1_rw       : req0_rw;
               sb_reg_addr_d = sel ? req1_reg_addr : req0_reg_addr;
               sb_data_in_d  = sel ? req1_data_in  : req0_data_in;
               state_d       = ST_BUS;
            end
         end

         ST_BUS: begin
            tmo_enable = 1'b1;
            // sb_ack takes precedence over an expiry in the same cycle
            if (sb_ack || tmo_expired) begin
               result        = completion_data(sb_rw, sb_ack, sb_data_out);
               sb_strobe_d   = 1'b0;
               timeout_err_d = !sb_ack;
               if (grant_id) begin
                  req1_ack_d      = 1'b1;
                  req1_data_out_d = result;
               end else begin
                  req0_ack_d      = 1'b1;
                  req0_data_out_d = result;
               end
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (!granted_strobe) begin
               req0_ack_d      = 1'b0;
               req1_ack_d      = 1'b0;
               req0_data_out_d = '0;
               req1_data_out_d = '0;
               prio_ptr_d      = !grant_id;
               state_d         = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         prio_ptr_q    <= 1'b0;
         grant_id      <= 1'b0;
         sb_strobe     <= 1'b0;
         sb_rw         <= 1'b0;
         sb_reg_addr   <= '0;
         sb_data_in    <= '0;
         req0_ack      <= 1'b0;
         req1_ack      <= 1'b0;
         req0_data_out <= '0;
         req1_data_out <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_ptr_q    <= prio_ptr_d;
         grant_id      <= grant_d;
         sb_strobe     <= sb_strobe_d;
         sb_rw         <= sb_rw_d;
         sb_reg_addr   <= sb_reg_addr_d;
         sb_data_in    <= sb_data_in_d;
         req0_ack      <= req0_ack_d;
         req1_ack      <= req1_ack_d;
         req0_data_out <= req0_data_out_d;
         req1_data_out <= req1_data_out_d;
         timeout_err   <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_ice40_sysbus_arbiter.sv
// tb_ice40_sysbus_arbiter
//   Scoreboard bench: stimulus pushes expected bus requests and expected
//   completions into queues; a monitor pops and compares them whenever the
//   DUT raises sb_strobe or a reqN_ack. A mock system-bus slave answers.
module tb_ice40_sysbus_arbiter;
   import ice40_sysbus_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_strobe = 1'b0, req0_rw = 1'b0;
   logic [7:0] req0_reg_addr = '0, req0_data_in = '0;
   logic       req1_strobe = 1'b0, req1_rw = 1'b0;
   logic [7:0] req1_reg_addr = '0, req1_data_in = '0;
   logic       req0_ack, req1_ack;
   logic [7:0] req0_data_out, req1_data_out;
   logic       sb_strobe, sb_rw;
   logic [7:0] sb_reg_addr, sb_data_in;
   logic [7:0] sb_data_out;
   logic       sb_ack;
   logic       timeout_err, grant_id;

   logic       mock_ack = 1'b0;
   logic       force_ack = 1'b0;
   logic [7:0] mock_rdata = 8'h00;
   logic       mock_never = 1'b0;
   int         mock_delay = 2;

   assign sb_ack      = mock_ack | force_ack;
   assign sb_data_out = mock_rdata;

   ice40_sysbus_arbiter #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req0_strobe   (req0_strobe),
      .req0_rw       (req0_rw),
      .req0_reg_addr (req0_reg_addr),
      .req0_data_in  (req0_data_in),
      .req0_ack      (req0_ack),
      .req0_data_out (req0_data_out),
      .req1_strobe   (req1_strobe),
      .req1_rw       (req1_rw),
      .req1_reg_addr (req1_reg_addr),
      .req1_data_in  (req1_data_in),
      .req1_ack      (req1_ack),
      .req1_data_out (req1_data_out),
      .sb_strobe     (sb_strobe),
      .sb_rw         (sb_rw),
      .sb_reg_addr   (sb_reg_addr),
      .sb_data_in    (sb_data_in),
      .sb_data_out   (sb_data_out),
      .sb_ack        (sb_ack),
      .timeout_err   (timeout_err),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         id;
      bit         rw;
      logic [7:0] addr;
      logic [7:0] data;
      bit         chk_lat;
      int         len;
   } bus_exp_t;

   typedef struct {
      bit         id;
      logic [7:0] rdata;
      bit         terr;
      bit         chk_lat;
   } done_exp_t;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];
   int        issue_cyc[2];
   int        n_checks = 0;
   int        n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_bus(input bit id, input bit rw, input logic [7:0] addr,
                           input logic [7:0] data, input bit chk_lat, input int len);
      bus_exp_t b;
      b.id = id; b.rw = rw; b.addr = addr; b.data = data; b.chk_lat = chk_lat; b.len = len;
      bus_q.push_back(b);
   endtask

   task automatic push_done(input bit id, input logic [7:0] rdata, input bit terr, input bit chk_lat);
      done_exp_t d;
      d.id = id; d.rdata = rdata; d.terr = terr; d.chk_lat = chk_lat;
      done_q.push_back(d);
   endtask

   // Mock slave: raises sb_ack on the mock_delay-th cycle of sb_strobe
   task automatic mock_loop();
      int cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (sb_strobe) begin
            cnt++;
            mock_ack = !mock_never && (cnt == mock_delay);
         end else begin
            cnt = 0;
            mock_ack = 1'b0;
         end
      end
   endtask

   task automatic monitor_loop();
      logic     prev_strobe = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0, prev_terr = 1'b0;
      int       cur_len = 0, cur_len_exp = 0, last_sbak_cyc = -10;
      bus_exp_t  b;
      done_exp_t d;
      forever begin
         @(negedge clk);
         if (sb_ack) last_sbak_cyc = cyc;

         if (sb_strobe && !prev_strobe) begin
            if (bus_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_bus_start: got sb_strobe=1 expected no request (cycle %0d)", cyc);
            end else begin
               b = bus_q.pop_front();
               check("bus_grant_id", grant_id, b.id);
               check("bus_rw", sb_rw, b.rw);
               check("bus_addr", sb_reg_addr, b.addr);
               check("bus_wdata", sb_data_in, b.data);
               if (b.chk_lat) check("strobe_latency", cyc, issue_cyc[b.id] + 1);
               cur_len_exp = b.len;
               cur_len = 1;
            end
         end else if (sb_strobe) begin
            cur_len++;
         end else if (prev_strobe && cur_len_exp != 0) begin
            check("strobe_length", cur_len, cur_len_exp);
         end

         if ((req0_ack && !prev_a0) || (req1_ack && !prev_a1)) begin
            if (done_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)",
                        req0_ack, req1_ack, cyc);
            end else begin
               d = done_q.pop_front();
               check("ack_which", {req1_ack, req0_ack}, d.id ? 2'b10 : 2'b01);
               check("ack_grant_id", grant_id, d.id);
               check("ack_rdata", d.id ? req1_data_out : req0_data_out, d.rdata);
               check("ack_timeout_err", timeout_err, d.terr);
               check("ack_strobe_low", sb_strobe, 1'b0);
               if (d.chk_lat) check("ack_latency", cyc, last_sbak_cyc + 1);
            end
         end

         if (req0_ack || req1_ack)
            check("ack_vs_grant", {req1_ack, req0_ack}, grant_id ? 2'b10 : 2'b01);
         if (prev_terr) check("timeout_err_pulse", timeout_err, 1'b0);

         prev_strobe = sb_strobe;
         prev_a0     = req0_ack;
         prev_a1     = req1_ack;
         prev_terr   = timeout_err;
      end
   endtask

   task automatic watchdog();
      #200us;
      $display("FAIL watchdog: got no end of test expected finish within 200us");
      $fatal(1, "watchdog expired");
   endtask

   task automatic set_req(input bit id, input logic strobe, input logic rw,
                          input logic [7:0] addr, input logic [7:0] data);
      if (id) begin
         req1_strobe = strobe; req1_rw = rw; req1_reg_addr = addr; req1_data_in = data;
      end else begin
         req0_strobe = strobe; req0_rw = rw; req0_reg_addr = addr; req0_data_in = data;
      end
   endtask

   // Full requester handshake: strobe until ack, drop, wait for ack release
   task automatic txn(input bit id, input logic rw, input logic [7:0] addr, input logic [7:0] data);
      int n;
      @(posedge clk); #1;
      issue_cyc[id] = cyc;
      set_req(id, 1'b1, rw, addr, data);
      n = 0;
      while (!(id ? req1_ack : req0_ack) && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 60) check("txn_ack_wait", 1'b0, 1'b1);
      set_req(id, 1'b0, rw, addr, data);
      n = 0;
      while ((id ? req1_ack : req0_ack) && n < 10) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 10) check("txn_ack_release", 1'b1, 1'b0);
   endtask

   initial begin
      int n;
      fork
         mock_loop();
         monitor_loop();
         watchdog();
      join_none

      // Reset state
      @(posedge clk); #1;
      check("rst_sb_strobe", sb_strobe, 1'b0);
      check("rst_sb_rw", sb_rw, 1'b0);
      check("rst_sb_addr", sb_reg_addr, 8'h00);
      check("rst_sb_wdata", sb_data_in, 8'h00);
      check("rst_req0_ack", req0_ack, 1'b0);
      check("rst_req1_ack", req1_ack, 1'b0);
      check("rst_req0_data", req0_data_out, 8'h00);
      check("rst_req1_data", req1_data_out, 8'h00);
      check("rst_timeout_err", timeout_err, 1'b0);
      check("rst_grant_id", grant_id, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;

      // req0 write to SPICR0, slave acks on its 2nd cycle; read data ignored
      mock_never = 1'b0; mock_delay = 2; mock_rdata = 8'h77;
      push_bus(1'b0, 1'b1, SPICR0, 8'hA5, 1'b1, 2);
      push_done(1'b0, 8'h00, 1'b0, 1'b1);
      txn(1'b0, 1'b1, SPICR0, 8'hA5);

      // req1 read of SPISR returns 8'h10
      mock_rdata = 8'h10;
      push_bus(1'b1, 1'b0, SPISR, 8'h00, 1'b1, 2);
      push_done(1'b1, 8'h10, 1'b0, 1'b1);
      txn(1'b1, 1'b0, SPISR, 8'h00);

      // Slave never acks: abort after 4 bus cycles, zero data, error pulse
      mock_never = 1'b1; mock_rdata = 8'hEE;
      push_bus(1'b0, 1'b0, SPIRXDR, 8'h00, 1'b1, 4);
      push_done(1'b0, 8'h00, 1'b1, 1'b0);
      txn(1'b0, 1'b0, SPIRXDR, 8'h00);

      // Ack lands in the same cycle as expiry: normal completion
      mock_never = 1'b0; mock_delay = 4; mock_rdata = 8'h5A;
      push_bus(1'b0, 1'b0, SPIBR, 8'h00, 1'b1, 4);
      push_done(1'b0, 8'h5A, 1'b0, 1'b1);
      txn(1'b0, 1'b0, SPIBR, 8'h00);

      // sb_ack while idle is ignored
      @(posedge clk); #1;
      force_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      force_ack = 1'b0;
      check("idle_ack_strobe", sb_strobe, 1'b0);
      check("idle_ack_acks", {req1_ack, req0_ack}, 2'b00);

      // Requester drops strobe mid-transaction: still completes, then releases
      mock_delay = 3; mock_rdata = 8'hC3;
      push_bus(1'b0, 1'b0, SPICSR, 8'h00, 1'b1, 3);
      push_done(1'b0, 8'hC3, 1'b0, 1'b1);
      @(posedge clk); #1;
      issue_cyc[0] = cyc;
      set_req(1'b0, 1'b1, 1'b0, SPICSR, 8'h00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, SPICSR, 8'h00);
      n = 0;
      while (!req0_ack && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("drop_ack_seen", req0_ack, 1'b1);
      @(posedge clk); #1;
      check("drop_ack_released", req0_ack, 1'b0);

      // Reset while the bus is busy: strobe drops at once, no ack
      mock_never = 1'b1;
      push_bus(1'b1, 1'b1, SPITXDR, 8'h99, 1'b0, 0);
      @(posedge clk); #1;
      set_req(1'b1, 1'b1, 1'b1, SPITXDR, 8'h99);
      n = 0;
      while (!sb_strobe && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("midbus_strobe_up", sb_strobe, 1'b1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("midbus_reset_strobe", sb_strobe, 1'b0);
      check("midbus_reset_acks", {req1_ack, req0_ack}, 2'b00);
      check("midbus_reset_grant", grant_id, 1'b0);
      set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("midbus_no_ack", {req1_ack, req0_ack}, 2'b00);
      reset = 1'b0;
      mock_never = 1'b0; mock_delay = 2; mock_rdata = 8'h3C;

      // Both requesters continuously: grants alternate starting with req0
      for (int k = 0; k < 4; k++) begin
         push_bus(1'b0, 1'b1, 8'(SPICR0 + k), 8'(8'hA0 + k), 1'b0, 2);
         push_done(1'b0, 8'h00, 1'b0, 1'b1);
         push_bus(1'b1, 1'b0, SPISR, 8'h00, 1'b0, 2);
         push_done(1'b1, 8'h3C, 1'b0, 1'b1);
      end
      fork
         begin
            for (int k = 0; k < 4; k++) txn(1'b0, 1'b1, 8'(SPICR0 + k), 8'(8'hA0 + k));
         end
         begin
            for (int j = 0; j < 4; j++) txn(1'b1, 1'b0, SPISR, 8'h00);
         end
      join

      repeat (5) @(posedge clk);
      #1;
      check("bus_queue_drained", bus_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
